// File: rtl/hpf_multichannel.sv
// Time-multiplexed first-order IIR high-pass filter (pole = 1 - 2^-k) for CHANNELS packed streams.
// Define HPF_SAT_EN to clamp the filter result instead of wrapping it to WIDTH bits.
module hpf_multichannel #(
    parameter int WIDTH    = 20,
    parameter int CHANNELS = 4,
    parameter int KW       = 4
) (
    input  logic                      qzt_clk,
    input  logic                      rst_n,
    input  logic                      clk_in,
    input  logic [KW-1:0]             k,
    input  logic                      bypass,
    input  logic [CHANNELS*WIDTH-1:0] vin,
    output logic [CHANNELS*WIDTH-1:0] vout,
    output logic                      vout_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
    localparam logic signed [WIDTH+1:0] S_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] S_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state;
    logic [CW-1:0]             ch_idx;
    logic                      clk_in_q;
    logic                      strobe_edge;
    logic [CHANNELS*WIDTH-1:0] vin_f;
    logic [KW-1:0]             k_f;
    logic                      bypass_f;
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic [CHANNELS*WIDTH-1:0] shadow_next;
    logic signed [WIDTH-1:0]   x_prev [CHANNELS];
    logic signed [WIDTH-1:0]   y_prev [CHANNELS];

    logic signed [WIDTH-1:0]   x;
    logic signed [WIDTH-1:0]   xp;
    logic signed [WIDTH-1:0]   yp;
    logic signed [WIDTH-1:0]   yp_sh;
    logic signed [WIDTH:0]     d;
    logic signed [WIDTH+1:0]   s;
    logic signed [WIDTH-1:0]   y_filt;
    logic signed [WIDTH-1:0]   y;

    assign strobe_edge = clk_in & ~clk_in_q;

    // Shared datapath: one channel per RUN cycle, selected by ch_idx.
    always_comb begin
        x      = vin_f[ch_idx*WIDTH +: WIDTH];
        xp     = x_prev[ch_idx];
        yp     = y_prev[ch_idx];
        yp_sh  = yp >>> k_f;
        d      = (WIDTH+1)'(x) - (WIDTH+1)'(xp);
        s      = (WIDTH+2)'(yp) - (WIDTH+2)'(yp_sh) + (WIDTH+2)'(d);
`ifdef HPF_SAT_EN
        if (s > S_MAX)
            y_filt = WIDTH'(S_MAX);
        else if (s < S_MIN)
            y_filt = WIDTH'(S_MIN);
        else
            y_filt = WIDTH'(s);
`else
        y_filt = WIDTH'(s);
`endif
        y = bypass_f ? x : y_filt;
    end

    // The final channel's result must reach vout in the same cycle it is computed.
    always_comb begin
        shadow_next = shadow;
        shadow_next[ch_idx*WIDTH +: WIDTH] = y;
    end

    // NOTE: the per-channel history arrays are reset explicitly; the filter
    // state must restart from zero, so they cannot be left as uninitialised RAM.
    always_ff @(posedge qzt_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_idx     <= '0;
            clk_in_q   <= 1'b1;
            vin_f      <= '0;
            k_f        <= '0;
            bypass_f   <= 1'b0;
            shadow     <= '0;
            vout       <= '0;
            vout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                x_prev[c] <= '0;
                y_prev[c] <= '0;
            end
        end else begin
            clk_in_q   <= clk_in;
            vout_valid <= 1'b0;
            overrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe_edge) begin
                        vin_f    <= vin;
                        k_f      <= k;
                        bypass_f <= bypass;
                        ch_idx   <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    overrun        <= strobe_edge;
                    shadow         <= shadow_next;
                    x_prev[ch_idx] <= x;
                    y_prev[ch_idx] <= bypass_f ? '0 : y_filt;
                    if (ch_idx == LAST_CH) begin
                        vout       <= shadow_next;
                        vout_valid <= 1'b1;
                        busy       <= 1'b0;
                        ch_idx     <= '0;
                        state      <= IDLE;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpf_multichannel.sv
// Directed bench for hpf_multichannel (WIDTH=20, CHANNELS=4); expectations adapt to HPF_SAT_EN.
module tb_hpf_multichannel;

    localparam int W = 20;
    localparam int C = 4;

    logic             qzt_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic             clk_in  = 1'b0;
    logic [3:0]       k       = '0;
    logic             bypass  = 1'b0;
    logic [W*C-1:0]   vin     = '0;
    logic [W*C-1:0]   vout;
    logic             vout_valid;
    logic             busy;
    logic             overrun;

    int total = 0;
    int bad   = 0;

    hpf_multichannel #(.WIDTH(W), .CHANNELS(C), .KW(4)) dut (
        .qzt_clk    (qzt_clk),
        .rst_n      (rst_n),
        .clk_in     (clk_in),
        .k          (k),
        .bypass     (bypass),
        .vin        (vin),
        .vout       (vout),
        .vout_valid (vout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic tick();
        @(posedge qzt_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W*C-1:0] obs, input logic [W*C-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*C-1:0] pack(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                            input logic [W-1:0] c2, input logic [W-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        clk_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One strobe; k/bypass are flipped right after the edge to show they are latched.
    task automatic run_frame(input logic [W*C-1:0] v, input logic [3:0] kk, input logic bp);
        int n;
        vin    = v;
        k      = kk;
        bypass = bp;
        clk_in = 1'b1;
        tick();
        check("busy_after_edge", W*C'(busy), W*C'(1'b1));
        clk_in = 1'b0;
        k      = ~kk;
        bypass = ~bp;
        n = 0;
        while (!vout_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", W*C'(n), W*C'(C));
        check("busy_at_valid", W*C'(busy), '0);
        tick();
        check("valid_one_cycle", W*C'(vout_valid), '0);
    endtask

    initial begin
        int extra;

        // Reset state
        do_reset();
        check("rst_vout", vout, '0);
        check("rst_valid", W*C'(vout_valid), '0);
        check("rst_busy", W*C'(busy), '0);
        check("rst_overrun", W*C'(overrun), '0);

        // Step response on ch0, k=4
        run_frame(pack(20'd1000, 0, 0, 0), 4'd4, 1'b0);
        check("step_f1", vout, pack(20'd1000, 0, 0, 0));
        run_frame(pack(20'd1000, 0, 0, 0), 4'd4, 1'b0);
        check("step_f2", vout, pack(20'd938, 0, 0, 0));
        run_frame(pack(20'd1000, 0, 0, 0), 4'd4, 1'b0);
        check("step_f3", vout, pack(20'd880, 0, 0, 0));

        // k=0 pure differentiator on ch1
        do_reset();
        run_frame(pack(0, 20'd500, 0, 0), 4'd0, 1'b0);
        check("k0_f1", vout, pack(0, 20'd500, 0, 0));
        run_frame(pack(0, 20'd300, 0, 0), 4'd0, 1'b0);
        check("k0_f2", vout, pack(0, 20'hFFF38, 0, 0));

        // Overflow on ch2, k=15
        do_reset();
        run_frame(pack(0, 0, 20'h80000, 0), 4'd15, 1'b0);
        check("ovf_f1", vout, pack(0, 0, 20'h80000, 0));
        run_frame(pack(0, 0, 20'h7FFFF, 0), 4'd15, 1'b0);
`ifdef HPF_SAT_EN
        check("ovf_f2_sat", vout, pack(0, 0, 20'h7FFFF, 0));
`else
        check("ovf_f2_wrap", vout, pack(0, 0, 20'h8000F, 0));
`endif

        // Overrun: second edge two cycles after the first
        do_reset();
        vin    = pack(20'd1000, 0, 0, 0);
        k      = 4'd4;
        bypass = 1'b0;
        clk_in = 1'b1;
        tick();
        clk_in = 1'b0;
        tick();
        check("ovr_none_e1", W*C'(overrun), '0);
        clk_in = 1'b1;
        tick();
        check("ovr_pulse", W*C'(overrun), W*C'(1'b1));
        clk_in = 1'b0;
        tick();
        check("ovr_one_cycle", W*C'(overrun), '0);
        check("ovr_busy_e3", W*C'(busy), W*C'(1'b1));
        tick();
        check("ovr_valid_e4", W*C'(vout_valid), W*C'(1'b1));
        check("ovr_vout", vout, pack(20'd1000, 0, 0, 0));
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vout_valid || busy) extra++;
        end
        check("ovr_no_second_frame", W*C'(extra), '0);

        // Reset mid-RUN, released with clk_in still high
        vin    = pack(20'd2000, 0, 0, 0);
        clk_in = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_vout", vout, '0);
        check("midrst_busy", W*C'(busy), '0);
        check("midrst_valid", W*C'(vout_valid), '0);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vout_valid || busy) extra++;
        end
        check("midrst_no_start", W*C'(extra), '0);
        clk_in = 1'b0;
        tick();
        run_frame(pack(20'd2000, 0, 0, 0), 4'd4, 1'b0);
        check("midrst_state_cleared", vout, pack(20'd2000, 0, 0, 0));

        // Bypass then filtered frame on ch3
        run_frame(pack(20'd2000, 0, 0, 20'd700), 4'd4, 1'b1);
        check("byp_f1", vout, pack(20'd2000, 0, 0, 20'd700));
        run_frame(pack(20'd2000, 0, 0, 20'd750), 4'd4, 1'b0);
        check("byp_f2", vout, pack(0, 0, 0, 20'd50));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpf_multichannel.md
# hpf_multichannel

Parametrised, time-multiplexed first-order IIR high-pass filter for the ECG front end. It removes baseline wander from CHANNELS signed sample streams sharing one sample strobe. Channels are processed sequentially through one shared datapath. All outputs are committed together with a one-cycle valid pulse. Supersedes the single-channel, fixed-width high-pass stage; downstream blocks consume vout on vout_valid.

## Interface
- WIDTH, 20, sample width (signed two's complement) per channel
- CHANNELS, 4, number of channels; 1..16
- KW, 4, width of shift-coefficient input k
- qzt_clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on qzt_clk
- clk_in  in  1  sample strobe (level); rising edge detected on qzt_clk
- k  in  KW  pole shift; pole = 1 - 2^-k
- bypass  in  1  1 = pass samples through unfiltered
- vin  in  CHANNELS*WIDTH  packed input; channel c at [c*WIDTH +: WIDTH]
- vout  out  CHANNELS*WIDTH  packed filtered output, same packing
- vout_valid  out  1  one-cycle pulse when vout updated
- busy  out  1  high while a frame is being processed
- overrun  out  1  one-cycle pulse: strobe edge arrived while busy

## Operation
- Edge detect: edge = clk_in & ~clk_in_q; clk_in_q <= clk_in every cycle, including while busy.
- States IDLE, RUN.
- IDLE + edge: latch vin, k, bypass into frame registers; ch_idx <= 0; go RUN, busy <= 1.
- RUN: each cycle processes channel ch_idx, writes result to shadow[ch_idx], updates per-channel state, ch_idx++.
- After channel CHANNELS-1: vout <= shadow (all channels at once); vout_valid <= 1 for one cycle; busy <= 0; go IDLE.
- Per channel c, with x = latched sample, xp = x_prev[c], yp = y_prev[c]:
  - d = x - xp, computed in WIDTH+1 bits.
  - s = yp - (yp >>> k) + d, computed in WIDTH+2 bits; >>> is an arithmetic shift.
  - k = 0 gives s = d (pure differentiator). k >= WIDTH gives (yp >>> k) equal to 0 or -1.
  - y = s reduced to WIDTH bits (see Configuration); output y; y_prev[c] <= y; x_prev[c] <= x.
- Bypass frame: output y = x; y_prev[c] <= 0; x_prev[c] <= x.
  - The first filtered frame after bypass gives y = x - x_prev.
- k and bypass changes mid-frame have no effect; the latched values are used.
- Edge while RUN: frame ignored, overrun pulses one cycle, current frame unaffected.
- An edge in the same cycle as the final RUN cycle is also ignored, with overrun.

## Timing
- Edge detected at clock edge E0 (clk_in = 1, clk_in_q = 0).
- Channel c computed at E(c+1).
- vout and vout_valid registered at E(CHANNELS); latency is CHANNELS cycles from E0.
- busy is high from after E0 until E(CHANNELS).
- Minimum strobe period for no overrun: CHANNELS+1 cycles.
- Reset (rst_n = 0 at a clock edge) forces:
  - vout = 0, vout_valid = 0, busy = 0, overrun = 0, state IDLE, ch_idx = 0.
  - all x_prev and y_prev = 0.
  - clk_in_q = 1, so clk_in held high across reset release creates no edge.
- Reset mid-RUN aborts the frame: no vout_valid, no partial vout update.

## Configuration
- HPF_SAT_EN defined: s is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before output and storage into y_prev.
- HPF_SAT_EN undefined: s is truncated to its low WIDTH bits (two's-complement wrap), matching the legacy filter.

## Test plan
- Step, WIDTH=20, CHANNELS=4, k=4: ch0 state 0, then vin ch0 = 1000 held for 3 frames -> ch0 outputs 1000, 938, 880; other channels (0) -> 0; vout_valid exactly 4 cycles after each edge.
- k=0: ch1 frames 500 then 300 -> outputs 500, then -200 (20'hFFF38).
- Overflow, ch2: frame -524288 then 524287, k=15.
  - First frame -> -524288.
  - Second frame: d = 1048575; yp >>> 15 = -16, so s = -524272 + 1048575 = 524303, outside [-524288, 524287].
  - With HPF_SAT_EN -> 524287 (20'h7FFFF).
  - Without -> wrapped to -524273 (20'h8000F).
- Overrun: second clk_in edge 2 cycles after the first -> overrun pulse in that cycle; only one vout_valid; results equal single-frame values.
- Reset mid-RUN: rst_n low during RUN cycle 2 -> next cycle vout = 0, busy = 0, no vout_valid. Release with clk_in already high -> no frame starts until clk_in falls and rises again.
- Bypass: bypass=1 frame with ch3 = 700 -> output 700. Next frame bypass=0, ch3 = 750, k=4 -> output 50.
